// File: rtl/spi_queue_ctrl_if.sv
// spi_queue_ctrl_if: command/status/SPI bus bundle for spi_queue_ctrl.
// Receive signals exist only when SPI_QUEUE_RX_EN is defined.
interface spi_queue_ctrl_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_CS     = 3
);
    logic [DATA_W+2:0]   din;
    logic                wr;
    logic                clr_err;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] level;
    logic                ovf;
    logic                bad_cs;
    logic                busy;
    logic [NUM_CS-1:0]   csn;
    logic                sck;
    logic                mosi;
    logic                dc;
`ifdef SPI_QUEUE_RX_EN
    logic                miso;
    logic [DATA_W-1:0]   rx_data;
    logic                rx_valid;

    modport slave (
        input  din, wr, clr_err, miso,
        output full, empty, level, ovf, bad_cs, busy, csn, sck, mosi, dc, rx_data, rx_valid
    );
    modport master (
        output din, wr, clr_err, miso,
        input  full, empty, level, ovf, bad_cs, busy, csn, sck, mosi, dc, rx_data, rx_valid
    );
`else
    modport slave (
        input  din, wr, clr_err,
        output full, empty, level, ovf, bad_cs, busy, csn, sck, mosi, dc
    );
    modport master (
        output din, wr, clr_err,
        input  full, empty, level, ovf, bad_cs, busy, csn, sck, mosi, dc
    );
`endif
endinterface

// File: rtl/spi_queue_ctrl.sv
// spi_queue_ctrl: command FIFO feeding a mode-0, MSB-first SPI master.
// Each word carries {cs_idx[1:0], dc, data}; consecutive words to the same
// chip select are sent as one burst with csn held low.
// Optional receive path (miso -> rx_data/rx_valid): define SPI_QUEUE_RX_EN.
module spi_queue_ctrl #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_CS     = 3,
    parameter int CLK_DIV    = 4
) (
    input logic             Bus2IP_Clk,
    input logic             rst,
    spi_queue_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WW    = DATA_W + 3;
    localparam int LW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP} state_t;

    // FIFO storage and pointers
    logic [WW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q;
    logic                  full, empty, push, pop;

    // head-of-queue fields
    logic [WW-1:0]         head;
    logic [1:0]            hd_cs;
    logic                  hd_dc;
    logic [DATA_W-1:0]     hd_data;
    logic                  hd_cs_ok;
    logic [NUM_CS-1:0]     hd_csn;

    // engine
    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_W-1:0]     tx_sr_q, tx_nxt;
    logic [1:0]            cs_q;
    logic [NUM_CS-1:0]     csn_q;
    logic                  sck_q, mosi_q, dc_q;
    logic                  ovf_q, bad_cs_q;
    logic                  cnt_done, last_bit, word_end, bad_pop;

    // Decode head word, phase/bit terminal counts and the pop decision
    always_comb begin
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        push     = bus.wr && !full;
        head     = mem_q[rd_ptr_q];
        hd_cs    = head[WW-1:WW-2];
        hd_dc    = head[DATA_W];
        hd_data  = head[DATA_W-1:0];
        hd_cs_ok = int'(hd_cs) < NUM_CS;
        hd_csn   = ~(NUM_CS'(1) << hd_cs);
        tx_nxt   = tx_sr_q << 1;
        cnt_done = (cnt_q == CW'(CLK_DIV - 1));
        last_bit = (bit_q == BW'(DATA_W - 1));
        word_end = (state_q == SHIFT_HI) && cnt_done && last_bit;
        pop      = 1'b0;
        if (!empty) begin
            if (state_q == IDLE)
                pop = 1'b1;
            else if (word_end && hd_cs == cs_q)
                pop = 1'b1;
        end
        // Invalid chip selects are only ever popped from IDLE; a burst
        // continuation requires a match with the (valid) current cs.
        bad_pop  = pop && (state_q == IDLE) && !hd_cs_ok;
    end

    // FIFO data write; storage needs no reset because pointers gate it
    always_ff @(posedge Bus2IP_Clk) begin
        if (push)
            mem_q[wr_ptr_q] <= bus.din;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at 2**DEPTH_LOG2
    always_ff @(posedge Bus2IP_Clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky error flags; a new event in the clear cycle keeps the flag set
    always_ff @(posedge Bus2IP_Clk) begin
        if (rst) begin
            ovf_q    <= 1'b0;
            bad_cs_q <= 1'b0;
        end else begin
            ovf_q    <= (ovf_q    && !bus.clr_err) || (bus.wr && full);
            bad_cs_q <= (bad_cs_q && !bus.clr_err) || bad_pop;
        end
    end

    // SPI engine FSM with registered bus outputs
    always_ff @(posedge Bus2IP_Clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_sr_q <= '0;
            cs_q    <= '0;
            csn_q   <= '1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            dc_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop && hd_cs_ok) begin
                        tx_sr_q <= hd_data;
                        cs_q    <= hd_cs;
                        csn_q   <= hd_csn;
                        dc_q    <= hd_dc;
                        mosi_q  <= hd_data[DATA_W-1];
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (cnt_done) begin
                        cnt_q   <= '0;
                        sck_q   <= 1'b1;
                        state_q <= SHIFT_HI;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        sck_q <= 1'b0;
                        if (!last_bit) begin
                            // mosi only moves on the falling sck edge
                            bit_q   <= bit_q + BW'(1);
                            tx_sr_q <= tx_nxt;
                            mosi_q  <= tx_nxt[DATA_W-1];
                            state_q <= SHIFT_LO;
                        end else if (pop) begin
                            // burst: same cs queued, keep csn low
                            tx_sr_q <= hd_data;
                            dc_q    <= hd_dc;
                            mosi_q  <= hd_data[DATA_W-1];
                            bit_q   <= '0;
                            state_q <= SHIFT_LO;
                        end else begin
                            csn_q   <= '1;
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (cnt_done) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_QUEUE_RX_EN
    logic [DATA_W-1:0] rx_sr_q, rx_data_q;
    logic              rx_valid_q;

    // Receive shifter: sample miso on each rising sck, publish at word end
    always_ff @(posedge Bus2IP_Clk) begin
        if (rst) begin
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q == SHIFT_LO && cnt_done)
                rx_sr_q <= DATA_W'({rx_sr_q, bus.miso});
            if (word_end) begin
                rx_data_q  <= rx_sr_q;
                rx_valid_q <= 1'b1;
            end
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`endif

    assign bus.full   = full;
    assign bus.empty  = empty;
    assign bus.level  = level_q;
    assign bus.ovf    = ovf_q;
    assign bus.bad_cs = bad_cs_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.csn    = csn_q;
    assign bus.sck    = sck_q;
    assign bus.mosi   = mosi_q;
    assign bus.dc     = dc_q;
endmodule
